// File: rtl/mem_wb_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pkg
// Shared definitions for the memory-access / write-back stage:
//   - state_e      : stage FSM states (IDLE, REQ, WB)
//   - DEF_DATA_W   : default datapath / address width
//   - DEF_REG_ADDR_W : default register index width
//   - DEF_TIMEOUT_CYC : default REQ-cycle budget used when MEM_TIMEOUT_EN is set
// -----------------------------------------------------------------------------
package mem_wb_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_REG_ADDR_W  = 3;
  localparam int DEF_TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_req_timer.sv
// -----------------------------------------------------------------------------
// mem_req_timer
// Counts the cycles spent waiting for a memory acknowledge.
// Ports:
//   clk    in  clock, rising edge
//   rstn   in  synchronous active-low reset
//   load   in  restart the count (new instruction accepted)
//   count  in  advance while the stage is in REQ
//   expire out high during the last allowed REQ cycle
// The counter saturates on the last allowed cycle; the stage decides whether
// an ack arriving in that same cycle wins over the expiry.
// -----------------------------------------------------------------------------
module mem_req_timer
  import mem_wb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // REQ cycle counter: cleared on load, advanced while counting, saturates on the last cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (count && (cnt_r != LAST_CNT)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // cnt_r == k-1 during the k-th REQ cycle, so this marks the TIMEOUT_CYC-th one
  assign expire = count && (cnt_r == LAST_CNT);

endmodule

// File: rtl/mem_writeback_stage.sv
// -----------------------------------------------------------------------------
// mem_writeback_stage
// Memory-access and write-back stage of the 16-bit RISC datapath. Accepts one
// executed instruction at a time, runs loads/stores over a req/ack memory port,
// then retires a single-cycle register-file write.
//
// Build option: define MEM_TIMEOUT_EN to abort a memory request that gets no
// ack within TIMEOUT_CYC REQ cycles (sets the sticky out_error flag). Without
// it REQ waits forever and out_error is tied low.
//
// Ports:
//   inp_clk, inp_rstn            clock / synchronous active-low reset
//   inp_valid, out_ready         upstream handshake (transfer = valid & ready)
//   inp_aluResult, inp_data2     ALU result (also address) / store data
//   inp_memRead, inp_memWrite,
//   inp_memToReg, inp_regWrite   control bits
//   inp_rd                       destination register
//   out_memReq, out_memWe,
//   out_memAddr, out_memWdata    memory request side
//   inp_memAck, inp_memRdata     memory completion / load data
//   out_regWe, out_regAddr,
//   out_regWdata                 register-file write port
//   out_error                    sticky timeout flag
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module mem_writeback_stage
  import mem_wb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  inp_clk,
  input  logic                  inp_rstn,
  input  logic                  inp_valid,
  output logic                  out_ready,
  input  logic [DATA_W-1:0]     inp_aluResult,
  input  logic [DATA_W-1:0]     inp_data2,
  input  logic                  inp_memRead,
  input  logic                  inp_memWrite,
  input  logic                  inp_memToReg,
  input  logic                  inp_regWrite,
  input  logic [REG_ADDR_W-1:0] inp_rd,
  output logic                  out_memReq,
  output logic                  out_memWe,
  output logic [DATA_W-1:0]     out_memAddr,
  output logic [DATA_W-1:0]     out_memWdata,
  input  logic                  inp_memAck,
  input  logic [DATA_W-1:0]     inp_memRdata,
  output logic                  out_regWe,
  output logic [REG_ADDR_W-1:0] out_regAddr,
  output logic [DATA_W-1:0]     out_regWdata,
  output logic                  out_error
);

  state_e                  state_r;
  state_e                  stateNext_s;
  logic [DATA_W-1:0]       aluResult_r;
  logic [DATA_W-1:0]       data2_r;
  logic [DATA_W-1:0]       rdata_r;
  logic                    memRead_r;
  logic                    memWrite_r;
  logic                    memToReg_r;
  logic                    regWrite_r;
  logic [REG_ADDR_W-1:0]   rd_r;
  logic                    xfer_s;
  logic                    inReq_s;
  logic                    expire_s;
  logic                    timeout_s;

  assign xfer_s  = inp_valid && (state_r == ST_IDLE);
  assign inReq_s = (state_r == ST_REQ);

`ifdef MEM_TIMEOUT_EN
  logic error_r;

  mem_req_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) uReqTimer (
    .clk    (inp_clk),
    .rstn   (inp_rstn),
    .load   (xfer_s),
    .count  (inReq_s),
    .expire (expire_s)
  );

  // An ack in the final allowed cycle still counts as success
  assign timeout_s = expire_s && !inp_memAck;

  // Sticky error flag, cleared only by reset
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      error_r <= 1'b0;
    end else if (timeout_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign out_error = error_r;
`else
  assign expire_s  = 1'b0;
  assign timeout_s = expire_s;
  assign out_error = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          if (inp_memRead || inp_memWrite) begin
            stateNext_s = ST_REQ;
          end else begin
            stateNext_s = ST_WB;
          end
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (inp_memAck) begin
          stateNext_s = ST_WB;
        end else if (timeout_s) begin
          stateNext_s = ST_IDLE;
        end else begin
          stateNext_s = ST_REQ;
        end
      end
      ST_WB: begin
        stateNext_s = ST_IDLE;
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // Instruction capture on transfer; load data latched on ack of a pure read
  always_ff @(posedge inp_clk) begin
    if (!inp_rstn) begin
      aluResult_r <= {DATA_W{1'b0}};
      data2_r     <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
      memRead_r   <= 1'b0;
      memWrite_r  <= 1'b0;
      memToReg_r  <= 1'b0;
      regWrite_r  <= 1'b0;
      rd_r        <= {REG_ADDR_W{1'b0}};
    end else begin
      if (xfer_s) begin
        aluResult_r <= inp_aluResult;
        data2_r     <= inp_data2;
        memRead_r   <= inp_memRead;
        memWrite_r  <= inp_memWrite;
        memToReg_r  <= inp_memToReg;
        regWrite_r  <= inp_regWrite;
        rd_r        <= inp_rd;
      end
      // read+write together is executed as a write, so rdata stays stale
      if (inReq_s && inp_memAck && memRead_r && !memWrite_r) begin
        rdata_r <= inp_memRdata;
      end
    end
  end

  assign out_ready    = (state_r == ST_IDLE);
  assign out_memReq   = inReq_s;
  assign out_memWe    = inReq_s && memWrite_r;
  assign out_memAddr  = aluResult_r;
  assign out_memWdata = data2_r;
  assign out_regWe    = (state_r == ST_WB) && regWrite_r && (rd_r != {REG_ADDR_W{1'b0}});
  assign out_regAddr  = rd_r;
  assign out_regWdata = memToReg_r ? rdata_r : aluResult_r;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_writeback_stage
// Self-checking bench for mem_writeback_stage: directed scenarios plus a
// randomized instruction stream checked against a behavioural model that
// tracks the last successfully loaded word.
// -----------------------------------------------------------------------------
module tb_mem_writeback_stage;

  localparam int DATA_W      = 16;
  localparam int REG_ADDR_W  = 3;
  localparam int TIMEOUT_CYC = 15;

  logic                  inp_clk = 1'b0;
  logic                  inp_rstn;
  logic                  inp_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     inp_aluResult;
  logic [DATA_W-1:0]     inp_data2;
  logic                  inp_memRead;
  logic                  inp_memWrite;
  logic                  inp_memToReg;
  logic                  inp_regWrite;
  logic [REG_ADDR_W-1:0] inp_rd;
  logic                  out_memReq;
  logic                  out_memWe;
  logic [DATA_W-1:0]     out_memAddr;
  logic [DATA_W-1:0]     out_memWdata;
  logic                  inp_memAck;
  logic [DATA_W-1:0]     inp_memRdata;
  logic                  out_regWe;
  logic [REG_ADDR_W-1:0] out_regAddr;
  logic [DATA_W-1:0]     out_regWdata;
  logic                  out_error;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] lastLoad;   // model: most recent word returned to a pure load

  mem_writeback_stage #(
    .DATA_W (DATA_W), .REG_ADDR_W (REG_ADDR_W), .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .inp_clk (inp_clk), .inp_rstn (inp_rstn), .inp_valid (inp_valid), .out_ready (out_ready),
    .inp_aluResult (inp_aluResult), .inp_data2 (inp_data2),
    .inp_memRead (inp_memRead), .inp_memWrite (inp_memWrite),
    .inp_memToReg (inp_memToReg), .inp_regWrite (inp_regWrite), .inp_rd (inp_rd),
    .out_memReq (out_memReq), .out_memWe (out_memWe),
    .out_memAddr (out_memAddr), .out_memWdata (out_memWdata),
    .inp_memAck (inp_memAck), .inp_memRdata (inp_memRdata),
    .out_regWe (out_regWe), .out_regAddr (out_regAddr), .out_regWdata (out_regWdata),
    .out_error (out_error)
  );

  always #5 inp_clk = ~inp_clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge inp_clk);
    #1;
  endtask

  // Wait (bounded) for ready, present one instruction for exactly one edge
  task automatic send(input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] d2,
                      input logic mr, input logic mw, input logic m2r, input logic rw,
                      input logic [REG_ADDR_W-1:0] rd);
    int n = 0;
    while (!out_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (out_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait: out_ready=%b required 1", out_ready);
    end
    inp_aluResult = alu;
    inp_data2     = d2;
    inp_memRead   = mr;
    inp_memWrite  = mw;
    inp_memToReg  = m2r;
    inp_regWrite  = rw;
    inp_rd        = rd;
    inp_valid     = 1'b1;
    tick();
    inp_valid     = 1'b0;
  endtask

  task automatic test_reset();
    inp_rstn = 1'b0;
    inp_valid = 1'b1;
    inp_aluResult = 16'hFFFF;
    inp_data2 = 16'hFFFF;
    inp_memRead = 1'b1;
    inp_memWrite = 1'b1;
    inp_memToReg = 1'b1;
    inp_regWrite = 1'b1;
    inp_rd = 3'd7;
    inp_memAck = 1'b1;
    inp_memRdata = 16'hFFFF;
    tick();
    tick();
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", out_ready); end
    checks++; if ({out_memReq, out_memWe, out_regWe, out_error} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes: req/we/regWe/err=%b want 0000", {out_memReq, out_memWe, out_regWe, out_error});
    end
    checks++; if ({out_memAddr, out_memWdata, out_regWdata} !== 48'd0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h regWdata=%h want 0", out_memAddr, out_memWdata, out_regWdata);
    end
    checks++; if (out_regAddr !== 3'd0) begin errors++; $display("FAIL reset_regAddr: got %0d want 0", out_regAddr); end
    inp_valid = 1'b0;
    inp_memAck = 1'b0;
    inp_rstn = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    send(16'h1234, 16'h0BAD, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    checks++; if (out_regWe !== 1'b1) begin errors++; $display("FAIL alu_regWe: got %b want 1", out_regWe); end
    checks++; if (out_regAddr !== 3'd3) begin errors++; $display("FAIL alu_regAddr: got %0d want 3", out_regAddr); end
    checks++; if (out_regWdata !== 16'h1234) begin errors++; $display("FAIL alu_regWdata: got %h want 1234", out_regWdata); end
    checks++; if ({out_ready, out_memReq} !== 2'b00) begin errors++; $display("FAIL alu_wb_ready: ready/req=%b want 00", {out_ready, out_memReq}); end
    tick();
    checks++; if ({out_ready, out_regWe} !== 2'b10) begin errors++; $display("FAIL alu_ready_back: ready/regWe=%b want 10", {out_ready, out_regWe}); end
  endtask

  task automatic test_load();
    send(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({out_memReq, out_memWe, out_ready, out_memAddr} !== {3'b100, 16'h0040}) begin
        errors++;
        $display("FAIL load_req%0d: req/we/ready=%b addr=%h want 100 0040", c, {out_memReq, out_memWe, out_ready}, out_memAddr);
      end
      if (c == 3) begin
        inp_memAck = 1'b1;
        inp_memRdata = 16'hBEEF;
      end
      tick();
      inp_memAck = 1'b0;
    end
    lastLoad = 16'hBEEF;
    checks++; if ({out_regWe, out_regAddr} !== {1'b1, 3'd5}) begin errors++; $display("FAIL load_wb: regWe/addr=%b/%0d want 1/5", out_regWe, out_regAddr); end
    checks++; if (out_regWdata !== 16'hBEEF) begin errors++; $display("FAIL load_data: got %h want BEEF", out_regWdata); end
    checks++; if (out_memReq !== 1'b0) begin errors++; $display("FAIL load_req_drop: got %b want 0", out_memReq); end
    tick();
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back: got %b want 1", out_ready); end
  endtask

  task automatic test_store();
    send(16'h0010, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    checks++;
    if ({out_memReq, out_memWe, out_memAddr, out_memWdata} !== {2'b11, 16'h0010, 16'hA5A5}) begin
      errors++;
      $display("FAIL store_req: req/we=%b addr=%h wdata=%h want 11 0010 A5A5", {out_memReq, out_memWe}, out_memAddr, out_memWdata);
    end
    inp_memAck = 1'b1;
    inp_memRdata = 16'h7777;
    tick();
    inp_memAck = 1'b0;
    checks++; if ({out_regWe, out_memReq, out_ready} !== 3'b000) begin errors++; $display("FAIL store_wb: regWe/req/ready=%b want 000", {out_regWe, out_memReq, out_ready}); end
    tick();
    checks++; if (out_ready !== 1'b1) begin errors++; $display("FAIL store_ready_back: got %b want 1", out_ready); end
  endtask

  task automatic test_r0();
    send(16'h5555, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    checks++; if ({out_regWe, out_ready} !== 2'b00) begin errors++; $display("FAIL r0_suppress: regWe/ready=%b want 00", {out_regWe, out_ready}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] rd1 = 16'($urandom);
    send(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    // valid stays high with a different instruction queued behind the load
    inp_valid = 1'b1;
    inp_aluResult = 16'h0777;
    inp_memRead = 1'b0;
    inp_memToReg = 1'b0;
    inp_regWrite = 1'b1;
    inp_rd = 3'd6;
    checks++; if (out_ready !== 1'b0) begin errors++; $display("FAIL b2b_req1_ready: got %b want 0", out_ready); end
    tick();
    checks++; if ({out_ready, out_memReq} !== 2'b01) begin errors++; $display("FAIL b2b_req2: ready/req=%b want 01", {out_ready, out_memReq}); end
    inp_memAck = 1'b1;
    inp_memRdata = rd1;
    tick();
    inp_memAck = 1'b0;
    lastLoad = rd1;
    checks++;
    if ({out_ready, out_regWe, out_regAddr, out_regWdata} !== {2'b01, 3'd1, rd1}) begin
      errors++;
      $display("FAIL b2b_wb1: ready/regWe=%b addr=%0d data=%h want 01 1 %h", {out_ready, out_regWe}, out_regAddr, out_regWdata, rd1);
    end
    tick();
    checks++; if ({out_ready, out_regWe} !== 2'b10) begin errors++; $display("FAIL b2b_idle: ready/regWe=%b want 10", {out_ready, out_regWe}); end
    tick();
    inp_valid = 1'b0;
    checks++;
    if ({out_ready, out_regWe, out_regAddr, out_regWdata} !== {2'b01, 3'd6, 16'h0777}) begin
      errors++;
      $display("FAIL b2b_wb2: ready/regWe=%b addr=%0d data=%h want 01 6 0777", {out_ready, out_regWe}, out_regAddr, out_regWdata);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [DATA_W-1:0] good = 16'($urandom);
    logic [DATA_W-1:0] junk = ~good;
    send(16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    inp_memAck = 1'b1;
    inp_memRdata = good;
    tick();
    inp_memAck = 1'b0;
    lastLoad = good;
    tick();
    // read+write together: executed as a write, memToReg returns the stale load word
    send(16'h0300, 16'h1111, 1'b1, 1'b1, 1'b1, 1'b1, 3'd4);
    if (inp_memRead && inp_memWrite) $display("ILLEGAL instruction: memRead and memWrite both set (rd=4)");
    checks++; if ({out_memReq, out_memWe} !== 2'b11) begin errors++; $display("FAIL illegal_write: req/we=%b want 11", {out_memReq, out_memWe}); end
    inp_memAck = 1'b1;
    inp_memRdata = junk;
    tick();
    inp_memAck = 1'b0;
    checks++; if (out_regWdata !== lastLoad) begin errors++; $display("FAIL illegal_stale: got %h want %h", out_regWdata, lastLoad); end
    tick();
  endtask

  task automatic test_reset_mid_req();
    send(16'h0400, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1);
    checks++; if (out_memReq !== 1'b1) begin errors++; $display("FAIL rstreq_req: got %b want 1", out_memReq); end
    inp_rstn = 1'b0;
    tick();
    inp_rstn = 1'b1;
    lastLoad = 16'h0000;
    checks++; if ({out_memReq, out_ready} !== 2'b01) begin errors++; $display("FAIL rstreq_drop: req/ready=%b want 01", {out_memReq, out_ready}); end
    inp_memAck = 1'b1;
    inp_memRdata = 16'hDEAD;
    tick();
    inp_memAck = 1'b0;
    checks++; if ({out_regWe, out_memReq, out_ready} !== 3'b001) begin errors++; $display("FAIL rstreq_late_ack: regWe/req/ready=%b want 001", {out_regWe, out_memReq, out_ready}); end
    tick();
    checks++; if (out_regWe !== 1'b0) begin errors++; $display("FAIL rstreq_no_wb: got %b want 0", out_regWe); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [DATA_W-1:0] alu = 16'($urandom);
      logic [DATA_W-1:0] d2 = 16'($urandom);
      logic [DATA_W-1:0] rdat = 16'($urandom);
      int kind = $urandom_range(0, 2);           // 0 alu, 1 load, 2 store
      logic m2r = 1'($urandom);
      logic rw = 1'($urandom);
      logic [REG_ADDR_W-1:0] rd = 3'($urandom);
      int delay = $urandom_range(1, 4);
      logic mr = (kind == 1);
      logic mw = (kind == 2);
      logic [DATA_W-1:0] expData;
      send(alu, d2, mr, mw, m2r, rw, rd);
      if (mr || mw) begin
        for (int c = 1; c <= delay; c++) begin
          checks++;
          if ({out_memReq, out_memWe, out_memAddr, out_memWdata} !== {1'b1, mw, alu, d2}) begin
            errors++;
            $display("FAIL rand%0d_req: req/we=%b addr=%h wdata=%h want 1%b %h %h", i, {out_memReq, out_memWe}, out_memAddr, out_memWdata, mw, alu, d2);
          end
          if (c == delay) begin
            inp_memAck = 1'b1;
            inp_memRdata = rdat;
          end
          tick();
          inp_memAck = 1'b0;
        end
        if (mr) lastLoad = rdat;
      end
      expData = m2r ? lastLoad : alu;
      checks++;
      if ({out_regWe, out_regAddr, out_regWdata, out_memReq} !== {(rw && (rd != 3'd0)), rd, expData, 1'b0}) begin
        errors++;
        $display("FAIL rand%0d_wb: regWe=%b addr=%0d data=%h req=%b want %b %0d %h 0", i, out_regWe, out_regAddr, out_regWdata, out_memReq, (rw && (rd != 3'd0)), rd, expData);
      end
      // stray ack during WB must be ignored
      inp_memAck = 1'($urandom);
      inp_memRdata = 16'($urandom);
      tick();
      inp_memAck = 1'b0;
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    send(16'h0500, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
    for (int c = 1; c <= TIMEOUT_CYC; c++) begin
      if (c == TIMEOUT_CYC) begin
        inp_memAck = 1'b1;
        inp_memRdata = 16'hC0DE;
      end
      tick();
      inp_memAck = 1'b0;
    end
    lastLoad = 16'hC0DE;
    checks++;
    if ({out_regWe, out_regWdata, out_error} !== {1'b1, 16'hC0DE, 1'b0}) begin
      errors++;
      $display("FAIL to_last_ack: regWe=%b data=%h err=%b want 1 C0DE 0", out_regWe, out_regWdata, out_error);
    end
    tick();
    send(16'h0600, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3);
    for (int c = 1; c <= TIMEOUT_CYC; c++) begin
      checks++; if (out_memReq !== 1'b1) begin errors++; $display("FAIL to_req%0d: got %b want 1", c, out_memReq); end
      tick();
    end
    checks++;
    if ({out_memReq, out_error, out_regWe, out_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL to_abort: req/err/regWe/ready=%b want 0101", {out_memReq, out_error, out_regWe, out_ready});
    end
    send(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    checks++; if ({out_error, out_regWe} !== 2'b11) begin errors++; $display("FAIL to_sticky: err/regWe=%b want 11", {out_error, out_regWe}); end
    tick();
    inp_rstn = 1'b0;
    tick();
    inp_rstn = 1'b1;
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", out_error); end
  endtask
`endif

  initial begin
    inp_valid = 1'b0;
    inp_memAck = 1'b0;
    inp_memRdata = 16'h0000;
    lastLoad = 16'h0000;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_r0();
    test_back_to_back();
    test_illegal();
    test_reset_mid_req();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
